// File: rtl/fifo_wr_arbiter.sv
`timescale 1ns/1ps
// fifo_wr_arbiter: round-robin burst arbiter in front of an async FIFO write port.
// Each grant is preceded by one arbitration bubble. A burst ends on a transfer
// that carries req_last, or on the transfer that reaches MAX_BURST words.
// Optional per-requester grant statistics are enabled with FIFO_ARB_STATS_EN.
//
// state | meaning
// IDLE  | arbitration bubble, no transfers, picks next requester from rr_ptr
// BURST | granted requester streams words while !wfull

module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 16,
  parameter int MAX_BURST = 8
) (
  input  logic                      wclk,
  input  logic                      wrst_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*DW-1:0]        req_data,
  input  logic [NREQ-1:0]           req_last,
  output logic [NREQ-1:0]           req_ready,
  input  logic                      wfull,
  output logic                      winc,
  output logic [DW-1:0]             wdata,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy,
  output logic [NREQ*16-1:0]        stat_grants
);

  localparam int GW = $clog2(NREQ);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state_q;
  logic [GW-1:0]   grant_q;
  logic [GW-1:0]   rr_ptr_q;
  logic [7:0]      cnt_q;
  logic [7:0]      cnt_d;
  logic            busy_q;

  logic            sel_found;
  logic [GW-1:0]   sel_idx;
  logic [GW-1:0]   cand;
  logic            xfer;
  logic            burst_done;
  logic [GW-1:0]   next_ptr;

  // First valid requester at or above rr_ptr, wrapping modulo NREQ
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = GW'((int'(rr_ptr_q) + k) % NREQ);
      if (!sel_found && req_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Transfer qualification; wrst_n gating keeps winc/req_ready low during reset
  always_comb begin
    xfer       = busy_q && wrst_n && req_valid[grant_q] && !wfull;
    cnt_d      = cnt_q + 8'd1;
    burst_done = req_last[grant_q] || (cnt_d == 8'(MAX_BURST));
    next_ptr   = (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
  end

  // Ready goes only to the granted requester and follows !wfull
  always_comb begin
    req_ready = '0;
    if (busy_q && wrst_n) req_ready[grant_q] = !wfull;
  end

  assign winc     = xfer;
  assign wdata    = req_data[grant_q*DW +: DW];
  assign grant_id = grant_q;
  assign busy     = busy_q;

  // Arbitration FSM with registered grant and busy
  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sel_found) begin
            grant_q <= sel_idx;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= BURST;
          end
        end
        BURST: begin
          if (xfer) begin
            cnt_q <= cnt_d;
            if (burst_done) begin
              rr_ptr_q <= next_ptr;
              busy_q   <= 1'b0;
              state_q  <= IDLE;
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] stat_q [NREQ];
  logic        grant_evt;

  assign grant_evt = (state_q == IDLE) && sel_found;

  // Saturating count of IDLE->BURST grants per requester
  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      for (int i = 0; i < NREQ; i++) stat_q[i] <= '0;
    end else if (grant_evt && (stat_q[sel_idx] != 16'hFFFF)) begin
      stat_q[sel_idx] <= stat_q[sel_idx] + 16'd1;
    end
  end

  // Pack counters onto the flat statistics port
  always_comb begin
    stat_grants = '0;
    for (int i = 0; i < NREQ; i++) stat_grants[i*16 +: 16] = stat_q[i];
  end
`else
  assign stat_grants = '0;
`endif

endmodule
